uart_rx_byte: RTL and testbench

//  Serial-to-byte front end of the command path. Oversamples the async rx pin, frames 8N1
//  (optionally 8E1/8O1) characters, and presents each byte on byte_out with a 1-cycle

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_baud_tick.sv | 16 +
 rtl/uart_rx_byte.sv | 111 +++++++++++
 tb/tb_uart_rx_byte.sv | 139 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and framing constants shared by the UART rx/tx byte engines
package uart_pkg;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick generator, one pulse every TICK_DIV clocks
module uart_baud_tick #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = !clr && cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: oversampling UART receiver, 8N1 (8E1/8O1 when UART_RX_PARITY_EN is defined)
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_available,
  output logic       frame_error,
  output logic       parity_error,
  output logic       busy
);
  localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;
  if (TICK_DIV < 1) begin : g_bad_div
    $error("uart_rx_byte: CLK_FREQ too low for BAUD*OVERSAMPLE");
  end
  state_t state, state_n;
  logic rx_m, rx_s, rx_prev;
  logic [TW-1:0] tcnt;
  logic [2:0] bcnt;
  logic [1:0] samp;
  logic [DATA_BITS-1:0] shift;
  logic tick, start_det, decide, vote, par_bad;
  assign start_det = state == ST_IDLE && rx_prev && !rx_s;
  assign decide = tick && tcnt == TW'(MID + 1);
  assign vote = (samp[1] & samp[0]) | (samp[1] & rx_s) | (samp[0] & rx_s);
  assign busy = state != ST_IDLE;
  uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (start_det),
    .tick(tick)
  );
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   state_n = start_det ? ST_START : ST_IDLE;
      ST_START:  state_n = decide ? (vote ? ST_IDLE : ST_DATA) : ST_START;
`ifdef UART_RX_PARITY_EN
      ST_DATA:   state_n = decide && bcnt == 3'(DATA_BITS - 1) ? ST_PARITY : ST_DATA;
      ST_PARITY: state_n = decide ? ST_STOP : ST_PARITY;
`else
      ST_DATA:   state_n = decide && bcnt == 3'(DATA_BITS - 1) ? ST_STOP : ST_DATA;
`endif
      ST_STOP:   state_n = decide ? ST_IDLE : ST_STOP;
      default:   state_n = ST_IDLE;
    endcase
  end
  // tcnt starts at 2 so the detect cycle and edge lag centre the 3 votes on the bit
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state          <= ST_IDLE;
      rx_m           <= 1'b1;
      rx_s           <= 1'b1;
      rx_prev        <= 1'b1;
      tcnt           <= '0;
      bcnt           <= '0;
      samp           <= '0;
      shift          <= '0;
      byte_out       <= '0;
      byte_available <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      state          <= state_n;
      rx_m           <= rx;
      rx_s           <= rx_m;
      rx_prev        <= rx_s;
      byte_available <= 1'b0;
      frame_error    <= 1'b0;
      if (start_det) begin
        tcnt <= TW'(2);
        bcnt <= '0;
      end else if (tick) tcnt <= tcnt + 1'b1;
      if (tick && (tcnt == TW'(MID - 1) || tcnt == TW'(MID))) samp <= {samp[0], rx_s};
      if (decide && state == ST_DATA) begin
        shift <= {vote, shift[DATA_BITS-1:1]};
        bcnt  <= bcnt + 1'b1;
      end
      if (decide && state == ST_STOP) begin
        if (!vote) frame_error <= 1'b1;
        else if (!par_bad) begin
          byte_out       <= shift;
          byte_available <= 1'b1;
        end
      end
    end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      par_bad      <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      parity_error <= 1'b0;
      if (decide && state == ST_PARITY) par_bad <= (^{shift, vote}) != PARITY_ODD;
      if (decide && state == ST_STOP && vote && par_bad) parity_error <= 1'b1;
    end
`else
  assign par_bad = 1'b0;
  assign parity_error = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed checks of uart_rx_byte at 16 clk per bit
module tb_uart_rx_byte;
  logic clk = 1'b0, rst = 1'b0, rx = 1'b1;
  logic [7:0] byte_out;
  logic byte_available, frame_error, parity_error, busy;
  int vecs = 0, errs = 0, cyc = 0, nfe = 0, npe = 0, strobe_cyc = 0, c0, n0, fe0;
  logic [7:0] got[$];
  logic [7:0] leaf[4] = '{8'h4C, 8'h45, 8'h41, 8'h46};

  uart_rx_byte #(.CLK_FREQ(1_000_000), .BAUD(62500), .OVERSAMPLE(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .byte_out      (byte_out),
    .byte_available(byte_available),
    .frame_error   (frame_error),
    .parity_error  (parity_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (byte_available) begin
      got.push_back(byte_out);
      strobe_cyc = cyc;
    end
    if (frame_error) nfe++;
    if (parity_error) npe++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bitv(input logic v);
    rx = v;
    repeat (16) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int par);
    bitv(1'b0);
    for (int i = 0; i < 8; i++) bitv(b[i]);
    if (par >= 0) bitv(par[0]);
    bitv(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_byte_out", byte_out, 8'h00);
    chk("rst_avail", byte_available, 0);
    chk("rst_ferr", frame_error, 0);
    chk("rst_perr", parity_error, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    idle(20);
    // single 8N1 byte
    c0 = cyc; n0 = got.size();
    send(8'h4C, 1'b1, -1);
    idle(32);
    chk("t1_count", got.size() - n0, 1);
    chk("t1_byte", byte_out, 8'h4C);
    chk("t1_latency", (strobe_cyc - c0 >= 149) && (strobe_cyc - c0 <= 155), 1);
    chk("t1_busy", busy, 0);
    chk("t1_nfe", nfe, 0);
    // 4-clock glitch
    n0 = got.size();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("t2_busy_hi", busy, 1);
    repeat (8) @(negedge clk);
    chk("t2_busy_lo", busy, 0);
    idle(40);
    chk("t2_count", got.size() - n0, 0);
    chk("t2_nfe", nfe, 0);
    chk("t2_hold", byte_out, 8'h4C);
    // framing error
    n0 = got.size();
    send(8'h45, 1'b0, -1);
    idle(32);
    chk("t3_nfe", nfe, 1);
    chk("t3_hold", byte_out, 8'h4C);
    chk("t3_count", got.size() - n0, 0);
    // back-to-back LEAF
    n0 = got.size();
    for (int i = 0; i < 4; i++) send(leaf[i], 1'b1, -1);
    idle(32);
    chk("t4_count", got.size() - n0, 4);
    for (int i = 0; i < 4; i++)
      if (got.size() > n0 + i) chk($sformatf("t4_byte%0d", i), got[n0+i], leaf[i]);
    // reset in the middle of a frame
    bitv(1'b0);
    for (int i = 0; i < 4; i++) bitv(1'b0);
    rst = 1'b0;
    #1;
    chk("t5_rst_byte", byte_out, 8'h00);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_avail", byte_available, 0);
    chk("t5_rst_ferr", frame_error, 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    idle(20);
    n0 = got.size(); fe0 = nfe;
    send(8'h31, 1'b1, -1);
    idle(32);
    chk("t5_count", got.size() - n0, 1);
    chk("t5_byte", byte_out, 8'h31);
    chk("t5_nfe", nfe - fe0, 0);
`ifdef UART_RX_PARITY_EN
    n0 = got.size();
    send(8'h41, 1'b1, 1);
    idle(32);
    chk("t6_npe", npe, 1);
    chk("t6_hold", byte_out, 8'h31);
    chk("t6_count_bad", got.size() - n0, 0);
    send(8'h41, 1'b1, 0);
    idle(32);
    chk("t6_byte", byte_out, 8'h41);
    chk("t6_count_good", got.size() - n0, 1);
    chk("t6_npe_after", npe, 1);
`else
    chk("t6_perr_tied", npe, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
